// File: rtl/axi_slave_mem_pkg.sv
// Shared types and constants for the axi_slave_mem burst memory responder.
package axi_slave_pkg;

  localparam logic RESP_OK   = 1'b0;
  localparam logic RESP_ERR  = 1'b1;
  localparam int   MAX_BEATS = 16;

  typedef enum logic [1:0] {RD_IDLE, RD_PREP, RD_BURST} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP}  wr_state_t;

endpackage

// File: rtl/axi_slave_mem_if.sv
// Simplified AXI-style bus between the team's bus master and the memory responder.
interface axi_slave_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
);
  logic                       ARVALID;
  logic [ADDR_W+LEN_W+ID_W-1:0] ARREQ;
  logic                       ARREADY;
  logic                       RVALID;
  logic                       RREADY;
  logic                       RLAST;
  logic [DATA_W:0]            RBEAT;
  logic                       AWVALID;
  logic [ADDR_W+ID_W-1:0]     AWREQ;
  logic                       AWREADY;
  logic                       WVALID;
  logic [DATA_W-1:0]          WDATA;
  logic                       WLAST;
  logic                       WREADY;
  logic                       BVALID;
  logic [ID_W:0]              BRESP;
  logic                       BREADY;

  modport master (
    output ARVALID, ARREQ, RREADY, AWVALID, AWREQ, WVALID, WDATA, WLAST, BREADY,
    input  ARREADY, RVALID, RLAST, RBEAT, AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  ARVALID, ARREQ, RREADY, AWVALID, AWREQ, WVALID, WDATA, WLAST, BREADY,
    output ARREADY, RVALID, RLAST, RBEAT, AWREADY, WREADY, BVALID, BRESP
  );
endinterface

// File: rtl/axi_slave_mem_array.sv
// Byte store: one synchronous write port and one enabled, registered read port.
// A read and write of the same address on one edge returns the old contents.
module axi_slave_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the store has no reset; contents must survive rst and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_slave_mem.sv
// Burst memory responder: independent read and write FSMs sharing one byte store.
// Addresses wrap modulo 2^ADDR_W; wrapped or overrun beats flag an error response.
module axi_slave_mem
  import axi_slave_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
) (
  input logic            clk,
  input logic            rst,
  axi_slave_mem_if.slave bus
);

  localparam int SUM_W  = ADDR_W + 1;
  localparam int BEAT_W = LEN_W + 1;

  logic alive;

  rd_state_t         rd_state, rd_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len, rd_beat, rd_beat_inc;
  logic              rd_last, rd_wrap, ar_fire, r_fire;
  logic [SUM_W-1:0]  rd_sum;

  wr_state_t         wr_state, wr_next;
  logic [ADDR_W-1:0] wr_addr;
  logic [ID_W-1:0]   wr_id;
  logic [BEAT_W-1:0] wr_beat;
  logic              wr_err, wr_overrun, aw_fire, w_fire;
  logic [SUM_W-1:0]  wr_sum;

  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_rdata;

  // Ready flags stay low through reset and rise on the first edge after release.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    alive <= !rst;
  end

  assign ar_fire     = (rd_state == RD_IDLE) && alive && bus.ARVALID;
  assign r_fire      = (rd_state == RD_BURST) && bus.RREADY;
  assign rd_last     = (rd_beat == rd_len);
  assign rd_beat_inc = rd_beat + LEN_W'(1);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rd_next     = rd_state;
    bus.ARREADY = 1'b0;
    bus.RVALID  = 1'b0;
    mem_re      = 1'b0;
    rd_sum      = {1'b0, rd_addr};
    unique case (rd_state)
      RD_IDLE: begin
        bus.ARREADY = alive;
        if (ar_fire) rd_next = RD_PREP;
      end
      RD_PREP: begin
        mem_re  = 1'b1;
        rd_next = RD_BURST;
      end
      RD_BURST: begin
        bus.RVALID = 1'b1;
        if (r_fire && rd_last) begin
          rd_next = RD_IDLE;
        end else if (r_fire) begin
          // Prefetch the next beat so a held RREADY streams one beat per cycle.
          mem_re = 1'b1;
          rd_sum = {1'b0, rd_addr} + SUM_W'(rd_beat_inc);
        end
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_beat  <= '0;
      rd_wrap  <= RESP_OK;
    end else begin
      rd_state <= rd_next;
      if (ar_fire) begin
        rd_addr <= bus.ARREQ[ADDR_W+LEN_W+ID_W-1 -: ADDR_W];
        rd_len  <= bus.ARREQ[LEN_W+ID_W-1 -: LEN_W];
        rd_beat <= '0;
      end
      if (mem_re) rd_wrap <= rd_sum[ADDR_W];
      if (r_fire && !rd_last) rd_beat <= rd_beat_inc;
    end
  end

  assign bus.RLAST = (rd_state == RD_BURST) && rd_last;
  assign bus.RBEAT = (rd_state == RD_BURST) ? {mem_rdata, rd_wrap} : '0;

  assign aw_fire    = (wr_state == WR_IDLE) && alive && bus.AWVALID;
  assign w_fire     = (wr_state == WR_DATA) && bus.WVALID;
  assign wr_overrun = wr_beat[LEN_W];
  assign wr_sum     = {1'b0, wr_addr} + SUM_W'(wr_beat);

  always_comb begin
    wr_next     = wr_state;
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b0;
    mem_we      = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        bus.AWREADY = alive;
        if (aw_fire) wr_next = WR_DATA;
      end
      WR_DATA: begin
        bus.WREADY = 1'b1;
        mem_we     = w_fire && !wr_overrun;
        if (w_fire && bus.WLAST) wr_next = WR_RESP;
      end
      WR_RESP: begin
        bus.BVALID = 1'b1;
        if (bus.BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      wr_addr  <= '0;
      wr_id    <= '0;
      wr_beat  <= '0;
      wr_err   <= RESP_OK;
    end else begin
      wr_state <= wr_next;
      if (aw_fire) begin
        wr_addr <= bus.AWREQ[ADDR_W+ID_W-1 -: ADDR_W];
        wr_id   <= bus.AWREQ[ID_W-1:0];
        wr_beat <= '0;
        wr_err  <= RESP_OK;
      end
      if (w_fire) begin
        // The counter parks at MAX_BEATS so later beats are absorbed unwritten.
        if (!wr_overrun) wr_beat <= wr_beat + BEAT_W'(1);
        if (wr_overrun || wr_sum[ADDR_W]) wr_err <= RESP_ERR;
      end
    end
  end

  assign bus.BRESP = (wr_state == WR_RESP) ? {wr_id, wr_err} : '0;

  axi_slave_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_sum[ADDR_W-1:0]),
    .wdata(bus.WDATA),
    .re   (mem_re),
    .raddr(rd_sum[ADDR_W-1:0]),
    .rdata(mem_rdata)
  );

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

Burst-capable memory responder for the simplified AXI-style bus used by the team's bus master. It contains two independent channels against a shared 256x8 byte store:

- a read channel that accepts a read address/length/ID and returns a data burst;
- a write channel that accepts a write address/ID, absorbs a data burst terminated by WLAST, and returns a write response.

It sits at the far end of the bus from the master and serves as the bench target for master verification.

## Interface
Parameters
- ADDR_W, 8, byte address width (memory depth 2^ADDR_W)
- DATA_W, 8, beat width
- ID_W, 4, transaction ID width
- LEN_W, 4, burst length field; beats = LEN+1 (max 16)

Ports
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- ARVALID  in  1  read address valid
- ARREQ  in  16  {ARADDR[15:8], ARLEN[7:4], ARID[3:0]}
- ARREADY  out  1  read address accepted
- RVALID  out  1  read beat valid
- RREADY  in  1  master accepts beat
- RLAST  out  1  final beat of read burst
- RBEAT  out  9  {RDATA[8:1], RRESP[0]}
- AWVALID  in  1  write address valid
- AWREQ  in  12  {AWADDR[11:4], AWID[3:0]}
- AWREADY  out  1  write address accepted
- WVALID  in  1  write beat valid
- WDATA  in  8  write beat
- WLAST  in  1  final write beat
- WREADY  out  1  write beat accepted
- BVALID  out  1  write response valid
- BRESP  out  5  {BID[4:1], BERR[0]}
- BREADY  in  1  master accepts response

## Operation
- Handshake rule: a transfer occurs on any rising edge where VALID && READY. The slave never drops RVALID or BVALID before the handshake.
- Read FSM RD_IDLE -> RD_PREP -> RD_BURST -> RD_IDLE:
  - RD_IDLE: ARREADY=1. On ARVALID, capture addr/len/id and go to RD_PREP.
  - RD_PREP: ARREADY=0 for one cycle while the first byte is fetched.
  - RD_BURST: RVALID=1, RDATA=mem[addr+beat]. RLAST=1 when beat==len. On handshake beat++. On handshake with RLAST, return to RD_IDLE.
- Write FSM WR_IDLE -> WR_DATA -> WR_RESP -> WR_IDLE:
  - WR_IDLE: AWREADY=1. On AWVALID, capture addr/id and clear beat.
  - WR_DATA: AWREADY=0, WREADY=1. On handshake, mem[addr+beat]<=WDATA and beat++. On handshake with WLAST, go to WR_RESP.
  - WR_RESP: WREADY=0, BVALID=1, BRESP={id, err}. On BREADY, return to WR_IDLE.
- Address arithmetic: modulo 2^ADDR_W. A beat whose address wrapped past 0xFF sets RRESP=1 (read) or latches err (write). The data is still transferred at the wrapped address.
- Write overrun: beats after the 16th without WLAST are acknowledged but not written, and err latches.
- Channel independence: both FSMs run concurrently. Same-address read and write in one cycle returns the old byte; the write lands.
- Memory contents are not cleared by rst.

## Timing
- Reset values: ARREADY=0, AWREADY=0, RVALID=0, RLAST=0, RBEAT=0, WREADY=0, BVALID=0, BRESP=0. IDLE ready flags assert the first cycle after rst deasserts.
- AR handshake at edge N: ARREADY low after N, RVALID high after N+1 (one bubble).
- Read throughput: one beat per cycle while RREADY is held high. A stalled beat holds RBEAT/RLAST stable.
- AW handshake at edge N: WREADY high after N. The WLAST handshake at edge M gives BVALID high after M, WREADY low after M.
- rst asserted mid-burst: both FSMs go to IDLE on that edge. A partially written burst stays written, and no response is issued.

## Structure
- Package axi_slave_pkg:
  - rd_state_t (RD_IDLE, RD_PREP, RD_BURST);
  - wr_state_t (WR_IDLE, WR_DATA, WR_RESP);
  - RESP_OK=0, RESP_ERR=1;
  - MAX_BEATS=16.
- Sub-module axi_slave_mem_array: 2^ADDR_W x DATA_W. One synchronous write port, one registered read port. Read-old-data on collision.
- Top: two FSMs, beat counters, request capture registers.

## Test plan
- Preload mem[0x10..0x13]=A0..A3. Read ARREQ=0x1030 (len 3, id 0), RREADY=1 -> RVALID two cycles after AR handshake; beats A0,A1,A2,A3; RLAST on 4th; RRESP=0.
- Write AWREQ=0x205 (addr 0x20, id 5), beats 11,22 with WLAST on 2nd, BREADY=1 -> BVALID the cycle after last beat; BRESP=0x0A; readback of 0x20/0x21 gives 11/22.
- Read ARREQ=0xFE20 (len 2) -> bytes from FE,FF,00; RRESP 0,0,1.
- Toggle RREADY low during beat 2 for 3 cycles -> RBEAT and RLAST held stable, no beat lost or duplicated.
- Concurrent read and write of address 0x40 (old 55, new 66) in the same cycle -> read returns 55; subsequent read returns 66.
- Assert rst during a read beat 1 of 4 -> RVALID=0 next cycle; ARREADY=1 cycle after release; a new burst runs correctly.
